mobius_seq_interp: RTL and testbench
====================================

Name: mobius_seq_interp

Overview:
- Sequential inverse (interpolation) Möbius transform over GF(2).
- Accepts an N-entry Boolean truth table as a stream of W-bit words. Computes the algebraic normal form (ANF) coefficients in place, one butterfly stage per clock. Streams the N coefficients back out as W-bit words.
- Sits at the opposite end of the combinational evaluation transform: evaluation maps ANF to truth table, and this block maps truth table back to ANF.
- Butterfly and index conventions match the combinational transform bit for bit, so chaining the two is the identity.

Parameters:
- N, 128, truth-table length in bits; power of two, N >= 2.
- LOG2_N, 7, log2(N); number of butterfly stages.
- W, 8, stream word width; W divides N, N/W >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts an input word this cycle.
- in_data  in  W  truth-table word.
- out_valid  out  1  output word valid.
- out_ready  in  1  sink accepts an output word.
- out_data  out  W  ANF coefficient word.
- busy  out  1  high in COMPUTE or DRAIN.
- frame_done  out  1  one-cycle pulse after the last output word is accepted.

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD; word counter and stage counter = 0.
  - N-bit buffer buf[0:N-1] = 0.
  - in_ready=0 while in reset, 1 from the first edge after release.
  - out_valid=0, out_data=0, busy=0, frame_done=0.
- Bit order:
  - Beat k (k = 0..N/W-1) maps to buf[k*W .. k*W+W-1].
  - in_data[W-1] maps to buf[k*W]; in_data[0] maps to buf[k*W+W-1].
  - out_data uses the same mapping.
- FSM states: LOAD, COMPUTE, DRAIN.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready edge writes beat (word counter) and increments the counter.
  - On the edge accepting beat N/W-1: word counter -> 0, stage counter -> 0, state -> COMPUTE.
  - in_valid low: no change.
- COMPUTE:
  - in_ready=0, out_valid=0; lasts exactly LOG2_N cycles.
  - At stage s, each edge performs, for blocks b = 0..2^s-1 and j = 0..h-1 with h = N/2^(s+1):
    - buf[b*2h+j+h] <= buf[b*2h+j+h] ^ buf[b*2h+j];
    - lower entries unchanged.
  - All N/2 XORs for a stage occur in the same edge, reading pre-edge values.
  - After stage LOG2_N-1: state -> DRAIN, word counter = 0.
- Latency: out_valid rises exactly LOG2_N edges after the edge that accepted the last input beat.
- DRAIN:
  - out_valid=1; out_data = word (word counter) of buf.
  - out_data stable while out_valid&!out_ready.
  - Each out_valid&out_ready edge increments the word counter.
  - On the edge accepting word N/W-1: state -> LOAD, frame_done=1 for exactly the following cycle, buf cleared to 0.
  - in_ready=0 throughout DRAIN.
- Throughput: in_ready rises the cycle after the last output handshake. The first beat of the next frame can be accepted in that cycle.
- No input/output overlap: in_valid is ignored outside LOAD; out_ready is ignored outside DRAIN.
- Reset asserted mid-frame (any state): immediate abort to the reset values. No partial output is emitted afterward.
- Purely GF(2): XOR only, no carries. All counters wrap only via explicit reset to 0 as specified.

Test Plan:
- N=8, LOG2_N=3, W=4, constant-1 table:
  - Stimulus: in beats 0xF, 0xF.
  - Required: out beats 0x8, 0x0 (ANF = 1); out_valid rises 3 edges after the second input handshake; frame_done pulses once.
- N=8, W=4, table 0b00001111:
  - Stimulus: in beats 0x0, 0xF.
  - Required: out beats 0x0, 0x8 (ANF coefficient at index 4 only).
- N=8, W=4, single one at index 0:
  - Stimulus: in beats 0x8, 0x0.
  - Required: out beats 0xF, 0xF (involution check).
- Default N=128, W=8, 200 random frames:
  - Each output frame must equal a golden in-place butterfly model.
  - Feeding the output frame back in must return the original truth table.
  - in_valid is randomly gapped.
- Backpressure, default parameters:
  - out_ready held low 5 cycles per word.
  - out_data and out_valid stable during the stall; exactly 16 handshakes; in_ready=0 until after the last one.
- Abort:
  - Assert rst_n=0 during COMPUTE stage 2, then release and send a fresh frame.
  - Outputs go to reset values immediately; only the fresh frame's correct ANF is emitted, with no residue from the aborted frame.

Source files
------------

// File: rtl/mobius_seq_interp.sv
`default_nettype none
// ============================================================================
// Module      : mobius_seq_interp
// Description : Sequential inverse (interpolation) Moebius transform over
//               GF(2). Loads an N-bit truth table as W-bit words, runs one
//               butterfly stage per clock, then streams the ANF
//               coefficients back out as W-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
module mobius_seq_interp #(
    parameter int N      = 128,
    parameter int LOG2_N = 7,
    parameter int W      = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy,
    output logic         frame_done
);

    localparam int c_words = N / W;
    localparam int c_wcb   = (c_words > 1) ? $clog2(c_words) : 1;
    localparam int c_scb   = $clog2(LOG2_N + 1);
    localparam int c_ib    = $clog2(N);
    localparam logic [c_wcb-1:0] c_last_word  = c_wcb'(c_words - 1);
    localparam logic [c_scb-1:0] c_last_stage = c_scb'(LOG2_N - 1);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [c_wcb-1:0]             r_word;
    logic [c_scb-1:0]             r_stage;
    logic [N-1:0]                 r_buf;        // r_buf[i] holds buf[i]
    logic                         r_in_ready;
    logic                         r_frame_done;

    logic                         w_in_fire;
    logic                         w_out_fire;
    logic                         w_last_word;
    logic                         w_last_stage;
    logic [c_ib-1:0]              w_base;
    logic [W-1:0]                 w_in_rev;
    logic [W-1:0]                 w_slice;
    logic [LOG2_N-1:0][N-1:0]     w_stage_res;
    logic [N-1:0]                 w_bfly;

    assign w_last_word  = (r_word == c_last_word);
    assign w_last_stage = (r_stage == c_last_stage);
    assign w_in_fire    = (r_state == LOAD) && in_valid && r_in_ready;
    assign w_out_fire   = (r_state == DRAIN) && out_ready;
    assign w_base       = c_ib'(r_word) * c_ib'(W);
    assign w_slice      = r_buf[w_base +: W];
    assign in_ready     = r_in_ready;
    assign frame_done   = r_frame_done;

    // Every stage's butterfly result is built in parallel; the current stage
    // counter picks one. Upper half of each 2h block absorbs its lower partner.
    genvar gs, gi;
    generate
        for (gs = 0; gs < LOG2_N; gs++) begin : g_stage
            localparam int c_half = N >> (gs + 1);
            for (gi = 0; gi < N; gi++) begin : g_bit
                if ((gi % (2 * c_half)) >= c_half) begin : g_upper
                    assign w_stage_res[gs][gi] = r_buf[gi] ^ r_buf[gi - c_half];
                end else begin : g_lower
                    assign w_stage_res[gs][gi] = r_buf[gi];
                end
            end
        end
    endgenerate

    // Select the butterfly result for the active stage; reverse word bit order
    // so the MSB of a stream word lines up with the lowest buffer index.
    always_comb begin
        w_bfly   = r_buf;
        w_in_rev = '0;
        for (int s = 0; s < LOG2_N; s++) begin
            if (r_stage == c_scb'(s)) begin
                w_bfly = w_stage_res[s];
            end
        end
        for (int t = 0; t < W; t++) begin
            w_in_rev[t] = in_data[W-1-t];
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        busy        = 1'b0;
        out_data    = '0;
        case (r_state)
            LOAD: begin
                if (w_in_fire && w_last_word) begin
                    w_state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                if (w_last_stage) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                for (int t = 0; t < W; t++) begin
                    out_data[W-1-t] = w_slice[t];
                end
                if (w_out_fire && w_last_word) begin
                    w_state_nxt = LOAD;
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    // State register; in_ready is registered so it stays low during reset and
    // rises on the first edge that lands in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= LOAD;
            r_in_ready   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_in_ready   <= (w_state_nxt == LOAD);
            r_frame_done <= w_out_fire && w_last_word;
        end
    end

    // Buffer and counters: word writes in LOAD, in-place stages in COMPUTE,
    // word reads and final clear in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word  <= '0;
            r_stage <= '0;
            r_buf   <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_in_fire) begin
                        r_buf[w_base +: W] <= w_in_rev;
                        if (w_last_word) begin
                            r_word  <= '0;
                            r_stage <= '0;
                        end else begin
                            r_word <= r_word + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    r_buf <= w_bfly;
                    if (w_last_stage) begin
                        r_stage <= '0;
                        r_word  <= '0;
                    end else begin
                        r_stage <= r_stage + 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_out_fire) begin
                        if (w_last_word) begin
                            r_word <= '0;
                            r_buf  <= '0;
                        end else begin
                            r_word <= r_word + 1'b1;
                        end
                    end
                end
                default: begin
                    r_word <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mobius_seq_interp.sv
`default_nettype none
// ============================================================================
// Module      : tb_mobius_seq_interp
// Description : Self-checking bench for mobius_seq_interp at default sizes.
//               Reference ANF is computed from the subset-sum definition.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mobius_seq_interp;

    localparam int N      = 128;
    localparam int LOG2_N = 7;
    localparam int W      = 8;
    localparam int WORDS  = N / W;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         busy;
    logic         frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;

    mobius_seq_interp #(.N(N), .LOG2_N(LOG2_N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Rising-edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Truth-table index x lives in bit x; stream word MSB is the lowest index.
    function automatic logic [W-1:0] word_of(input logic [N-1:0] tbl, input int k);
        logic [W-1:0] w;
        for (int t = 0; t < W; t++) w[W-1-t] = tbl[k*W+t];
        return w;
    endfunction

    // ANF coefficient u is the XOR of f(x) over all x whose bits are a subset of u.
    function automatic logic [N-1:0] anf(input logic [N-1:0] f);
        logic [N-1:0] a;
        a = '0;
        for (int u = 0; u < N; u++) begin
            for (int x = 0; x < N; x++) begin
                if ((x & ~u) == 0) a[u] = a[u] ^ f[x];
            end
        end
        return a;
    endfunction

    function automatic logic [N-1:0] rand_tbl();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a falling edge; returns at the falling edge after the last beat.
    task automatic send_frame(input logic [N-1:0] tbl, input bit gapped);
        int budget;
        for (int k = 0; k < WORDS; k++) begin
            if (gapped) repeat ($urandom_range(0, 2)) @(negedge clk);
            in_valid = 1'b1;
            in_data  = word_of(tbl, k);
            budget   = 100;
            while (!in_ready && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (budget == 0) begin
                check("in_ready_timeout", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
            last_acc = cyc + 1;
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = '0;
        end
    endtask

    // Collects one output frame, optionally stalling each word, and checks it.
    task automatic recv_check(input logic [N-1:0] exp, input int stall, input string tag);
        int budget;
        for (int k = 0; k < WORDS; k++) begin
            budget = 100;
            while (!out_valid && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (budget == 0) begin
                check({tag, "_out_valid_timeout"}, out_valid, 1);
                return;
            end
            if (k == 0) begin
                check({tag, "_latency"}, cyc - last_acc, LOG2_N);
                check({tag, "_busy"}, busy, 1);
            end
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check($sformatf("%s_stall_data_w%0d", tag, k), out_data, word_of(exp, k));
                check($sformatf("%s_stall_valid_w%0d", tag, k), out_valid, 1);
            end
            check($sformatf("%s_data_w%0d", tag, k), out_data, word_of(exp, k));
            check($sformatf("%s_in_ready_w%0d", tag, k), in_ready, 0);
            if (k == WORDS - 1) in_valid = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check({tag, "_frame_done"}, frame_done, 1);
        check({tag, "_in_ready_after"}, in_ready, 1);
        check({tag, "_out_valid_after"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_frame_done_pulse"}, frame_done, 0);
    endtask

    initial begin
        logic [N-1:0] t;
        logic [N-1:0] a;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_in_ready", in_ready, 1);

        // Directed: constant-1 table has ANF = 1
        send_frame({N{1'b1}}, 1'b0);
        recv_check(128'h1, 0, "const1");

        // Directed: f(x) = x6 gives a single coefficient at index 64
        send_frame({{(N/2){1'b1}}, {(N/2){1'b0}}}, 1'b0);
        recv_check(128'h1_0000_0000_0000_0000, 0, "upper_half");

        // Directed: single one at index 0 gives all-ones ANF
        send_frame(128'h1, 1'b0);
        recv_check({N{1'b1}}, 0, "delta0");

        // Random frames with gapped input, plus round trip back to the table
        for (int i = 0; i < 100; i++) begin
            t = rand_tbl();
            a = anf(t);
            send_frame(t, 1'b1);
            recv_check(a, 0, "rand_fwd");
            send_frame(a, 1'b1);
            recv_check(t, 0, "rand_inv");
        end

        // Backpressure with junk on in_valid, which must be ignored outside LOAD
        t = rand_tbl();
        send_frame(t, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        recv_check(anf(t), 5, "bp");
        in_data = '0;

        // Abort during stage 2 of COMPUTE, then a fresh frame
        t = rand_tbl();
        send_frame(t, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        check("abort_frame_done", frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_release_in_ready", in_ready, 1);
        check("abort_release_out_valid", out_valid, 0);
        t = rand_tbl();
        send_frame(t, 1'b1);
        recv_check(anf(t), 0, "abort_fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
